// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Synchronizes the board reset button and the clock-wizard lock flags into
//   the controller clock domain, waits for STRETCH cycles of continuous "ok",
//   then releases N_OUT active-low domain resets one at a time, GAP cycles
//   apart. Any loss of "ok" drops every output together and restarts from HOLD.
//
//   Optional feature: define RESET_SEQ_LOSS_COUNT_EN to add the saturating
//   loss_count output (counts RUN -> HOLD transitions caused by loss of "ok").
//
// Ports
//   CLK        : controller clock, all logic on posedge
//   RST_N      : synchronous active-low reset
//   ext_rst    : asynchronous active-high board reset button
//   locked     : [N_LOCK] asynchronous PLL/MMCM lock flags
//   rst_n_out  : [N_OUT] registered, sequenced active-low resets (bit 0 first)
//   seq_done   : high when every rst_n_out bit is released
//   loss_count : [CNT_W] saturating ok-loss counter (macro builds only)
module reset_sequencer #(
    parameter int N_LOCK      = 1,
    parameter int N_OUT       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int GAP         = 4,
    parameter int CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ext_rst,
    input  logic [N_LOCK-1:0] locked,
    output logic [N_OUT-1:0]  rst_n_out,
    output logic              seq_done
`ifdef RESET_SEQ_LOSS_COUNT_EN
    ,
    output logic [CNT_W-1:0]  loss_count
`endif
);

    localparam int MAX_CNT = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam int IW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_t;

    // Synchronizer chains; index SYNC_STAGES-1 is the synchronized value.
    // ext chain resets asserted so the outputs stay held until the button
    // has genuinely been seen released.
    logic [SYNC_STAGES-1:0]             ext_sync;
    logic [SYNC_STAGES-1:0][N_LOCK-1:0] lock_sync;
    logic                               ok;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [N_OUT-1:0] rst_nxt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ext_sync  <= '1;
            lock_sync <= '0;
        end else begin
            ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_rst};
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign ok = !ext_sync[SYNC_STAGES-1] && (&lock_sync[SYNC_STAGES-1]);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            idx       <= '0;
            rst_n_out <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            rst_n_out <= rst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_n_out;
        if (!ok) begin
            // Assertion is immediate and simultaneous from any state.
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rst_nxt   = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    state_nxt = ST_STRETCH;
                    cnt_nxt   = '0;
                end
                ST_STRETCH: begin
                    // cnt starts at 0 on entry, so release lands STRETCH
                    // edges after the edge that first saw ok.
                    if (cnt == CW'(STRETCH - 1)) begin
                        rst_nxt[0] = 1'b1;
                        cnt_nxt    = '0;
                        idx_nxt    = '0;
                        state_nxt  = (N_OUT == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt == CW'(GAP - 1)) begin
                        cnt_nxt = '0;
                        idx_nxt = idx + IW'(1);
                        for (int k = 1; k < N_OUT; k++) begin
                            if (IW'(k) == idx + IW'(1)) begin
                                rst_nxt[k] = 1'b1;
                                if (k == N_OUT - 1) state_nxt = ST_RUN;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    rst_nxt = '1;
                end
                default: begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    rst_nxt   = '0;
                end
            endcase
        end
    end

    // RUN is entered on the same edge the last output bit is released.
    assign seq_done = (state == ST_RUN);

`ifdef RESET_SEQ_LOSS_COUNT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            loss_count <= '0;
        end else if (state == ST_RUN && !ok && loss_count != {CNT_W{1'b1}}) begin
            loss_count <= loss_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       ext_rst = 1'b0;
    logic [1:0] locked = 2'b00;
    logic [2:0] rst_n_out;
    logic       seq_done;
    int         errors = 0;
    int         checks = 0;
    int         exp_loss = 0;

`ifdef RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_count;
    logic [2:0] rst_n_out2;
    logic       seq_done2;
    logic [1:0] loss_count2;
`endif

    always #5 CLK = ~CLK;

    reset_sequencer #(
        .N_LOCK(2), .N_OUT(3), .SYNC_STAGES(2), .STRETCH(16), .GAP(4), .CNT_W(8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ext_rst   (ext_rst),
        .locked    (locked),
        .rst_n_out (rst_n_out),
        .seq_done  (seq_done)
`ifdef RESET_SEQ_LOSS_COUNT_EN
        ,
        .loss_count(loss_count)
`endif
    );

`ifdef RESET_SEQ_LOSS_COUNT_EN
    // Narrow-counter instance sharing the same stimulus, for saturation.
    reset_sequencer #(
        .N_LOCK(2), .N_OUT(3), .SYNC_STAGES(2), .STRETCH(16), .GAP(4), .CNT_W(2)
    ) dut2 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ext_rst   (ext_rst),
        .locked    (locked),
        .rst_n_out (rst_n_out2),
        .seq_done  (seq_done2),
        .loss_count(loss_count2)
    );
`endif

    // Advance n posedges and settle 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drop lock and wait until the FSM has seen it (outputs low).
    task automatic go_hold();
        locked = 2'b00;
        step(3);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; locked = 2'b00; ext_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (rst_n_out !== 3'b000 || seq_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_cyc%0d: got out=%b done=%b, want 000/0", i, rst_n_out, seq_done);
            end
        end
`ifdef RESET_SEQ_LOSS_COUNT_EN
        checks++;
        if (loss_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_loss: got %0d want 0", loss_count);
        end
`endif
        RST_N = 1'b1;
        step(5);
        checks++;
        if (rst_n_out !== 3'b000 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL hold_unlocked: got out=%b done=%b, want 000/0", rst_n_out, seq_done);
        end
    endtask

    // locked=11 sampled at edge E: bit0 at E+18, bit1 at E+22, bit2 at E+26.
    task automatic test_bringup();
        locked = 2'b11;
        step(18);
        checks++;
        if (rst_n_out !== 3'b000) begin
            errors++; $display("FAIL bringup_e17: got %b want 000", rst_n_out);
        end
        step(1);
        checks++;
        if (rst_n_out !== 3'b001) begin
            errors++; $display("FAIL bringup_e18: got %b want 001", rst_n_out);
        end
        step(3);
        checks++;
        if (rst_n_out !== 3'b001) begin
            errors++; $display("FAIL bringup_e21: got %b want 001", rst_n_out);
        end
        step(1);
        checks++;
        if (rst_n_out !== 3'b011) begin
            errors++; $display("FAIL bringup_e22: got %b want 011", rst_n_out);
        end
        step(3);
        checks++;
        if (rst_n_out !== 3'b011 || seq_done !== 1'b0) begin
            errors++; $display("FAIL bringup_e25: got %b/%b want 011/0", rst_n_out, seq_done);
        end
        step(1);
        checks++;
        if (rst_n_out !== 3'b111 || seq_done !== 1'b1) begin
            errors++; $display("FAIL bringup_e26: got %b/%b want 111/1", rst_n_out, seq_done);
        end
    endtask

    task automatic test_lock_loss();
        locked = 2'b10;
        step(2);
        checks++;
        if (rst_n_out !== 3'b111) begin
            errors++; $display("FAIL loss_e1: got %b want 111", rst_n_out);
        end
        step(1);
        exp_loss++;
        checks++;
        if (rst_n_out !== 3'b000 || seq_done !== 1'b0) begin
            errors++; $display("FAIL loss_e2: got %b/%b want 000/0", rst_n_out, seq_done);
        end
`ifdef RESET_SEQ_LOSS_COUNT_EN
        checks++;
        if (loss_count !== 8'(exp_loss)) begin
            errors++; $display("FAIL loss_count1: got %0d want %0d", loss_count, exp_loss);
        end
`endif
        locked = 2'b11;
        step(18);
        checks++;
        if (rst_n_out !== 3'b000) begin
            errors++; $display("FAIL relock_e17: got %b want 000", rst_n_out);
        end
        step(1);
        checks++;
        if (rst_n_out !== 3'b001) begin
            errors++; $display("FAIL relock_e18: got %b want 001", rst_n_out);
        end
        step(8);
        checks++;
        if (rst_n_out !== 3'b111 || seq_done !== 1'b1) begin
            errors++; $display("FAIL relock_e26: got %b/%b want 111/1", rst_n_out, seq_done);
        end
    endtask

    // One-cycle drop of locked[1] sampled at E+10: release moves to E+29.
    task automatic test_glitch();
        go_hold();
        exp_loss++;
        locked = 2'b11;
        step(10);
        locked = 2'b01;
        step(1);
        locked = 2'b11;
        step(8);
        checks++;
        if (rst_n_out !== 3'b000) begin
            errors++; $display("FAIL glitch_e18: got %b want 000", rst_n_out);
        end
        step(10);
        checks++;
        if (rst_n_out !== 3'b000) begin
            errors++; $display("FAIL glitch_e28: got %b want 000", rst_n_out);
        end
        step(1);
        checks++;
        if (rst_n_out !== 3'b001 || seq_done !== 1'b0) begin
            errors++; $display("FAIL glitch_e29: got %b/%b want 001/0", rst_n_out, seq_done);
        end
    endtask

    task automatic test_button();
        go_hold();
        locked = 2'b11;
        step(20);
        checks++;
        if (rst_n_out !== 3'b001) begin
            errors++; $display("FAIL button_pre: got %b want 001", rst_n_out);
        end
        ext_rst = 1'b1;
        step(2);
        checks++;
        if (rst_n_out !== 3'b001) begin
            errors++; $display("FAIL button_e1: got %b want 001", rst_n_out);
        end
        step(1);
        checks++;
        if (rst_n_out !== 3'b000 || seq_done !== 1'b0) begin
            errors++; $display("FAIL button_e2: got %b/%b want 000/0", rst_n_out, seq_done);
        end
        ext_rst = 1'b0;
        step(18);
        checks++;
        if (rst_n_out !== 3'b000) begin
            errors++; $display("FAIL button_rel_e17: got %b want 000", rst_n_out);
        end
        step(1);
        checks++;
        if (rst_n_out !== 3'b001) begin
            errors++; $display("FAIL button_rel_e18: got %b want 001", rst_n_out);
        end
`ifdef RESET_SEQ_LOSS_COUNT_EN
        checks++;
        if (loss_count !== 8'(exp_loss)) begin
            errors++; $display("FAIL button_loss: got %0d want %0d", loss_count, exp_loss);
        end
`endif
    endtask

    // RST_N mid-RUN wins immediately; sequence restarts after release.
    task automatic test_rst_priority();
        go_hold();
        locked = 2'b11;
        step(27);
        checks++;
        if (rst_n_out !== 3'b111) begin
            errors++; $display("FAIL prio_run: got %b want 111", rst_n_out);
        end
        RST_N = 1'b0;
        step(1);
        exp_loss = 0;
        checks++;
        if (rst_n_out !== 3'b000 || seq_done !== 1'b0) begin
            errors++; $display("FAIL prio_rst: got %b/%b want 000/0", rst_n_out, seq_done);
        end
        RST_N = 1'b1;
        step(18);
        checks++;
        if (rst_n_out !== 3'b000) begin
            errors++; $display("FAIL prio_rel_e17: got %b want 000", rst_n_out);
        end
        step(1);
        checks++;
        if (rst_n_out !== 3'b001) begin
            errors++; $display("FAIL prio_rel_e18: got %b want 001", rst_n_out);
        end
    endtask

    task automatic test_saturation();
        go_hold();
        for (int i = 0; i < 5; i++) begin
            locked = 2'b11;
            step(27);
            checks++;
            if (rst_n_out !== 3'b111 || seq_done !== 1'b1) begin
                errors++; $display("FAIL sat_run%0d: got %b/%b want 111/1", i, rst_n_out, seq_done);
            end
            locked = 2'b00;
            step(3);
            exp_loss++;
            checks++;
            if (rst_n_out !== 3'b000) begin
                errors++; $display("FAIL sat_drop%0d: got %b want 000", i, rst_n_out);
            end
        end
`ifdef RESET_SEQ_LOSS_COUNT_EN
        checks++;
        if (loss_count !== 8'(exp_loss)) begin
            errors++; $display("FAIL sat_count8: got %0d want %0d", loss_count, exp_loss);
        end
        checks++;
        if (loss_count2 !== 2'd3) begin
            errors++; $display("FAIL sat_count2: got %0d want 3", loss_count2);
        end
        RST_N = 1'b0;
        step(1);
        checks++;
        if (loss_count !== 8'd0 || loss_count2 !== 2'd0) begin
            errors++; $display("FAIL sat_clear: got %0d/%0d want 0/0", loss_count, loss_count2);
        end
        RST_N = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_loss();
        test_glitch();
        test_button();
        test_rst_priority();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset sequencer for board top levels: synchronizes an external reset button and N clock-wizard `locked` flags into the controller clock domain and qualifies them. It then releases N_OUT active-low domain resets in a fixed order, after a stretch delay and with a fixed gap between releases. It replaces the single-flop `RST_N` generation in the top wrapper, sitting between the clock wizard and the CPU/DDR3/peripheral instances.

## Interface
- `N_LOCK`, 1: number of `locked` inputs; all must be high for "ok".
- `N_OUT`, 2: number of sequenced reset outputs; ≥1.
- `SYNC_STAGES`, 2: synchronizer depth on `ext_rst` and each `locked` bit; ≥2.
- `STRETCH`, 16: cycles of continuous "ok" before the first release; ≥1.
- `GAP`, 4: cycles between successive releases; ≥1, unused when N_OUT=1.
- `CNT_W`, 8: width of `loss_count` (exists only with the macro).
- `CLK` in 1: single clock, controller domain; all logic on posedge.
- `RST_N` in 1: reset, synchronous, active-low.
- `ext_rst` in 1: asynchronous, active-high board reset.
- `locked` in N_LOCK: asynchronous PLL/MMCM lock flags.
- `rst_n_out` out N_OUT: sequenced active-low resets, registered; bit 0 released first.
- `seq_done` out 1: high when every `rst_n_out` bit is released.
- `loss_count` out CNT_W: saturating count of ok-loss events while in RUN (macro only).

## Operation
- Synchronizers: `ext_rst` chain resets to 1 (asserted), each `locked` chain resets to 0. `ok = !ext_s && &locked_s`.
- FSM states: HOLD, STRETCH, RELEASE, RUN. One shared counter sized `$clog2(max(STRETCH,GAP))+1`, plus an index `idx` of width `$clog2(N_OUT)` (min 1).
- HOLD:
  - All `rst_n_out` = 0, `seq_done` = 0, counter = 0.
  - Moves to STRETCH on the edge where `ok` = 1.
- STRETCH:
  - The counter counts continuous `ok` cycles.
  - `ok` = 0 returns the FSM to HOLD with the counter cleared. The count restarts from zero, even after a one-cycle glitch.
  - On completion, raises `rst_n_out[0]`, sets `idx` = 0 and enters RELEASE. If N_OUT = 1, it enters RUN instead.
- RELEASE: every GAP cycles, raises `rst_n_out[idx+1]` and increments `idx`. When the last bit is raised, enters RUN.
- RUN:
  - All outputs are 1 and `seq_done` = 1.
  - Stays in RUN while `ok` = 1.
- Any state with `ok` = 0: at that edge, all `rst_n_out` drop to 0 simultaneously, `seq_done` drops to 0, and the FSM returns to HOLD. Assertion is never sequenced; release always is.
- Released bits never fall except through the return to HOLD. Bits are monotonic within one sequence.
- `RST_N` low at an edge:
  - FSM = HOLD, counter = 0, `idx` = 0.
  - Synchronizers are set to their reset values.
  - `rst_n_out` = 0, `seq_done` = 0, `loss_count` = 0.
  - Takes priority over everything, including mid-sequence.

## Timing
- The first synchronizer flop samples the pin at edge E. The FSM sees the synchronized value at edge c = E + SYNC_STAGES.
- Release: `rst_n_out[k]` rises at edge c + STRETCH + k·GAP. `seq_done` rises at the same edge as `rst_n_out[N_OUT-1]`.
- Assertion latency: a pin fall of `locked`, or a rise of `ext_rst`, sampled at edge E' gives all outputs low after edge E' + SYNC_STAGES. This is a fixed latency with no combinational path from pins to outputs.
- Reset values: `rst_n_out` = 0, `seq_done` = 0, `loss_count` = 0.

## Configuration
- `RESET_SEQ_LOSS_COUNT_EN` defined:
  - `loss_count` port exists.
  - Increments by 1 on each RUN→HOLD transition caused by `ok` = 0.
  - Saturates at 2^CNT_W−1 and clears only via `RST_N`.
- Undefined: the port is absent and no counter logic is built. All other behaviour is identical.

## Test plan
All scenarios use N_LOCK=2, N_OUT=3, SYNC_STAGES=2, STRETCH=16, GAP=4.
- Power-up: `RST_N` low for 3 edges, `locked` = 00, `ext_rst` = 0 -> `rst_n_out` = 000, `seq_done` = 0 throughout.
- Normal bring-up: `locked` = 11 sampled at edge E=10 -> `rst_n_out[0]` rises at 28, `[1]` at 32, `[2]` and `seq_done` at 36.
- Glitch during stretch: `locked[1]` low for one cycle, sampled at edge 20 -> counter restarts; `rst_n_out[0]` rises at 22+1+16 = 39 rather than 28.
- Lock loss in RUN: `locked[0]` falls, sampled at edge 100 -> all outputs 0 after edge 102, `seq_done` = 0, `loss_count` 0→1 (macro on). Relock sampled at 110 -> `[0]` rises at 128.
- Button mid-RELEASE: `ext_rst` high sampled at edge 30 (only bit 0 released) -> all outputs 0 after edge 32. Release at 16+ cycles after `ext_rst` low is seen.
- Saturation (CNT_W=2, macro on): 5 RUN losses -> `loss_count` = 3; then `RST_N` low -> 0.
